control_bus_rtc: RTL

CONTROL_BUS_RTC -- requirements
Module: control_bus_rtc

---
 rtl/control_bus_rtc.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/control_bus_rtc.sv
// Multiplexed address/data bus sequencer for an RTC chip: address phase, then data phase, each setup/pulse/hold timed.
// Optional post-transaction guard interval is enabled by defining RTC_GUARD_EN.
module control_bus_rtc #(
    parameter int T_SETUP = 4,
    parameter int T_PULSE = 10,
    parameter int T_HOLD  = 4,
    parameter int T_GUARD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] dir,
    input  logic [7:0] dato_wr,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       cs_n,
    output logic       ad_sel,
    output logic       wr_n,
    output logic       rd_n,
    output logic [7:0] dato_leido,
    output logic       busy,
    output logic       done
);

    if (T_SETUP < 1 || T_SETUP > 31) begin : g_bad_setup
        $error("T_SETUP out of range 1..31");
    end
    if (T_PULSE < 1 || T_PULSE > 31) begin : g_bad_pulse
        $error("T_PULSE out of range 1..31");
    end
    if (T_HOLD < 1 || T_HOLD > 31) begin : g_bad_hold
        $error("T_HOLD out of range 1..31");
    end
    if (T_GUARD < 1 || T_GUARD > 31) begin : g_bad_guard
        $error("T_GUARD out of range 1..31");
    end

    typedef enum logic [3:0] {
        IDLE,
        A_SU,
        A_PUL,
        A_HD,
        D_SU,
        D_PUL,
        D_HD,
`ifdef RTC_GUARD_EN
        GUARD,
`endif
        DONE
    } state_t;

    localparam logic [4:0] SU_LAST  = 5'(T_SETUP - 1);
    localparam logic [4:0] PUL_LAST = 5'(T_PULSE - 1);
    localparam logic [4:0] HD_LAST  = 5'(T_HOLD - 1);
`ifdef RTC_GUARD_EN
    localparam logic [4:0] GD_LAST  = 5'(T_GUARD - 1);
`endif

    state_t     state;
    state_t     state_next;
    logic [4:0] cnt;
    logic       rw_q;
    logic [7:0] dir_q;
    logic [7:0] dat_q;
    logic       capture;

    assign capture = (state == D_PUL) && (cnt == PUL_LAST) && rw_q;

    // Counter restarts whenever the state changes, so each timed state sees 0..T-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            dato_leido <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state_next != state) ? 5'd0 : cnt + 5'd1;
            if (capture) begin
                dato_leido <= bus_in;
            end
        end
    end

    // Transaction operands are only consumed outside IDLE, so they need no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            rw_q  <= rw;
            dir_q <= dir;
            dat_q <= dato_wr;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start)             state_next = A_SU;
            A_SU:  if (cnt == SU_LAST)    state_next = A_PUL;
            A_PUL: if (cnt == PUL_LAST)   state_next = A_HD;
            A_HD:  if (cnt == HD_LAST)    state_next = D_SU;
            D_SU:  if (cnt == SU_LAST)    state_next = D_PUL;
            D_PUL: if (cnt == PUL_LAST)   state_next = D_HD;
`ifdef RTC_GUARD_EN
            D_HD:  if (cnt == HD_LAST)    state_next = GUARD;
            GUARD: if (cnt == GD_LAST)    state_next = DONE;
`else
            D_HD:  if (cnt == HD_LAST)    state_next = DONE;
`endif
            DONE:                         state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    always_comb begin
        cs_n    = 1'b1;
        ad_sel  = 1'b0;
        wr_n    = 1'b1;
        rd_n    = 1'b1;
        bus_oe  = 1'b0;
        bus_out = 8'h00;
        busy    = (state != IDLE);
        done    = (state == DONE);
        case (state)
            A_SU, A_HD: begin
                cs_n    = 1'b0;
                bus_oe  = 1'b1;
                bus_out = dir_q;
            end
            A_PUL: begin
                cs_n    = 1'b0;
                wr_n    = 1'b0;
                bus_oe  = 1'b1;
                bus_out = dir_q;
            end
            D_SU, D_HD: begin
                cs_n   = 1'b0;
                ad_sel = 1'b1;
                if (!rw_q) begin
                    bus_oe  = 1'b1;
                    bus_out = dat_q;
                end
            end
            D_PUL: begin
                cs_n   = 1'b0;
                ad_sel = 1'b1;
                if (rw_q) begin
                    rd_n = 1'b0;
                end else begin
                    wr_n    = 1'b0;
                    bus_oe  = 1'b1;
                    bus_out = dat_q;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
